uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_tx.sv | 124 ++++++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, 8N1 frame constants and the baud divisor.
// Used by the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        UART_START_BIT = 1'b0;
    localparam logic        UART_STOP_BIT  = 1'b1;

    // Clock cycles per bit, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered count; head byte is visible on data_o
// without a pop, so the consumer loads it on the same edge it pops.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop FSM with a
// down-counting baud timer. tx and busy are registered from the current state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 60000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          wr_en_i,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          tx_o
);
    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          pop;
    logic [7:0]    head;
    logic          fifo_empty;
    logic          bit_end;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (wr_en_i),
        .data_i  (wr_data_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full_o),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign bit_end = (baud_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        tx_d       = UART_STOP_BIT;
        busy_d     = (state_q != ST_IDLE) || !fifo_empty;
        if (state_q != ST_IDLE && !bit_end) baud_cnt_d = baud_cnt_q - CNT_ONE;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = head;
                    state_d    = ST_START;
                    baud_cnt_d = BAUD_RELOAD;
                end
            end
            ST_START: begin
                tx_d = UART_START_BIT;
                if (bit_end) begin
                    state_d    = ST_DATA;
                    bit_idx_d  = '0;
                    baud_cnt_d = BAUD_RELOAD;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (bit_end) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line monitor decodes frames and checks them against a
// scoreboard queue; directed sequences cover latency, burst, collision and reset.
module tb_uart_tx;
    localparam int D = 10;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, wr_en, wr_en2;
    logic [7:0] wr_data, wr_data2;
    logic       full, busy, tx, full2, busy2, tx2;
    logic [2:0] count, count2;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [9:0] exp_q[$];
    int         start_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset), .wr_data_i(wr_data), .wr_en_i(wr_en),
        .full_o(full), .count_o(count), .busy_o(busy), .tx_o(tx)
    );

    uart_tx dut_def (
        .clk_i(clk), .reset_i(reset), .wr_data_i(wr_data2), .wr_en_i(wr_en2),
        .full_o(full2), .count_o(count2), .busy_o(busy2), .tx_o(tx2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [7:0] d, output int w);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        w     = cyc;
        wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, (busy || exp_q.size() != 0)}, 32'd0);
    endtask

    // Decode every frame on tx: all D cycles of each bit must match its first cycle.
    initial begin : mon
        logic [9:0] fr, e;
        logic       ok, ab;
        int         st;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                st = cyc; ok = 1'b1; ab = 1'b0; fr = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < D; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (reset) ab = 1'b1;
                        if (k == 0) fr[b] = tx;
                        else if (tx !== fr[b]) ok = 1'b0;
                    end
                end
                if (!ab) begin
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL frame_unexpected: got %h with none expected", fr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", {ok, fr}, {1'b1, e});
                    end
                end
            end
        end
    end

    initial begin : main
        vec_t tbl[4];
        int   w, w0, w1, t, t0, n;
        logic lvl;

        tbl[0] = '{data: 8'h00, frame: 10'h200};
        tbl[1] = '{data: 8'hFF, frame: 10'h3FE};
        tbl[2] = '{data: 8'h3C, frame: 10'h278};
        tbl[3] = '{data: 8'h81, frame: 10'h302};

        // Reset with wr_en held high: nothing may be enqueued.
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; wr_en2 = 1'b0; wr_data2 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1); chk("rst_count", count, 0);
        chk("rst_full", full, 0); chk("rst_busy", busy, 0);
        chk("rst_def_count", count2, 0);
        reset = 1'b0; wr_en = 1'b0;
        @(negedge clk);

        // Single byte 0xA5: latency and frame timing.
        start_q.delete();
        exp_q.push_back(10'h34A);
        wr(8'hA5, w);
        chk("a5_count_push", count, 1);
        @(negedge clk);
        chk("a5_count_pop", count, 0); chk("a5_tx_idle", tx, 1); chk("a5_busy", busy, 1);
        @(negedge clk);
        chk("a5_tx_start", tx, 0);
        wait_cyc(w + 101);
        chk("a5_stop", tx, 1); chk("a5_busy_last", busy, 1);
        wait_cyc(w + 102);
        chk("a5_busy_low", busy, 0);
        chk("a5_start_edge", (start_q.size() != 0) ? start_q[0] : -1, w + 2);

        // Table of single bytes.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(tbl[i].frame);
            wr(tbl[i].data, w);
            chk("tbl_count", count, 1);
            wait_idle("tbl_idle");
        end

        // Burst of six into a depth-4 FIFO: sixth write dropped, no idle gaps.
        start_q.delete();
        w0 = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back({1'b1, 8'(i), 1'b0});
            wr(8'(i), w);
            if (i == 1) w0 = w;
            if (i >= 5) begin
                chk("burst_full", full, 1);
                chk("burst_count", count, 4);
            end
        end
        wait_cyc(w0 + 400); chk("burst_count_1", count, 1);
        wait_cyc(w0 + 401); chk("burst_count_0", count, 0);
        wait_cyc(w0 + 501); chk("burst_busy_last", busy, 1);
        wait_cyc(w0 + 502); chk("burst_busy_low", busy, 0);
        chk("burst_frames", start_q.size(), 5);
        for (int i = 0; i < start_q.size(); i++)
            chk("burst_start", start_q[i], w0 + 2 + 100 * i);

        // Push coincident with the STOP-end pop.
        exp_q.push_back({1'b1, 8'h11, 1'b0}); wr(8'h11, w);
        exp_q.push_back({1'b1, 8'h22, 1'b0}); wr(8'h22, w1);
        exp_q.push_back({1'b1, 8'h33, 1'b0}); wr(8'h33, w1);
        wait_cyc(w + 100);
        chk("coll_count_pre", count, 2);
        exp_q.push_back({1'b1, 8'h44, 1'b0});
        wr(8'h44, w1);
        chk("coll_edge", w1, w + 101);
        chk("coll_count", count, 2);
        wait_idle("coll_idle");

        // Reset at cycle 45 of a 0xFF frame with one byte still queued.
        wr(8'hFF, w);
        wr(8'h12, w1);
        wait_cyc(w + 44);
        chk("rst45_count_pre", count, 1);
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        chk("rst45_tx", tx, 1); chk("rst45_count", count, 0);
        chk("rst45_busy", busy, 0); chk("rst45_full", full, 0);
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        chk("rst45_wr_ignored", count, 0);
        wait_cyc(w + 110);

        // Reset during the start bit forces the line high on the next edge.
        wr(8'h00, w);
        wait_cyc(w + 4);
        chk("rst_start_tx_low", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_start_tx", tx, 1); chk("rst_start_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(w + 110);

        exp_q.push_back(10'h2B4);
        wr(8'h5A, w);
        wait_idle("clean_idle");

        // Default parameters: 0x55 toggles the line every bit period.
        wr_data2 = 8'h55; wr_en2 = 1'b1;
        @(negedge clk);
        w = cyc; wr_en2 = 1'b0;
        chk("def_count", count2, 1); chk("def_full", full2, 0);
        n = 0;
        while (tx2 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("def_start_edge", cyc, w + 2);
        t = cyc; t0 = cyc; lvl = 1'b0;
        for (int k = 1; k < 10; k++) begin
            n = 0;
            while (tx2 === lvl && n < 600) begin @(negedge clk); n++; end
            chk("def_bit_period", cyc - t, 520);
            t = cyc; lvl = tx2;
        end
        n = 0;
        while (busy2 && n < 600) begin @(negedge clk); n++; end
        chk("def_frame", cyc - t0, 5200);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
